cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
Execution controller that sits between the board clock domain and the parametrised single-cycle CPU core. It gates the core with a clock enable and supports run, single-step, stop, breakpoint-on-PC and a cycle limit. A circular buffer captures a PC/instruction trace of every executed cycle. This replaces fixed free-running clock-count simulation with a controllable, synthesizable run/halt mechanism.

Parameters:
PC_W, 16, program counter width
INSTR_W, 20, instruction width
CYC_W, 16, cycle counter / cycle limit width
TRACE_DEPTH, 8, trace entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command strobe
cmd  in  2  0=RUN, 1=STEP, 2=STOP, 3=CLEAR
cmd_ready  out  1  command accepted this cycle when high with cmd_valid
bp_en  in  1  breakpoint enable
bp_pc  in  PC_W  breakpoint address
cyc_limit  in  CYC_W  cycle limit; 0 = unlimited
pc  in  PC_W  core PC of instruction executing this cycle
instruction  in  INSTR_W  core instruction this cycle
cpu_en  out  1  core clock enable; core state updates only when high
state  out  2  0=IDLE, 1=RUN, 2=STEP, 3=HALT
cycle_count  out  CYC_W  executed-cycle count, saturating
halt_reason  out  2  0=none, 1=breakpoint, 2=cycle limit, 3=host stop
trace_rd  in  1  pop oldest trace entry
trace_valid  out  1  buffer non-empty
trace_data  out  PC_W+INSTR_W  oldest entry {pc, instruction}
trace_count  out  clog2(TRACE_DEPTH)+1  occupancy
trace_ovf  out  1  sticky overwrite flag

Behaviour:
- Reset (async on rst_n low, mid-operation included): state=IDLE, cpu_en=0, cycle_count=0, halt_reason=0, trace empty, trace_ovf=0; buffer contents don't-care.
- cpu_en is combinational from registered state: 1 in RUN and STEP, else 0.
- cmd_ready = 1 in all states, except RUN only accepts STOP (RUN/STEP/CLEAR in RUN: cmd_ready=0, ignored).
- IDLE/HALT + RUN -> RUN; + STEP -> STEP; + STOP -> no change; + CLEAR -> IDLE, cycle_count=0, halt_reason=0, trace emptied, trace_ovf=0.
- STEP: exactly one cycle with cpu_en=1, then HALT, halt_reason=0 (unless a higher halt condition fires that cycle).
- RUN, per executed cycle, priority: breakpoint > cycle limit > host STOP.
  - Breakpoint: bp_en && pc==bp_pc -> instruction at bp_pc is NOT executed. cpu_en forced 0 that cycle (combinational on pc compare), no trace push, no count; next state HALT, reason=1. After a breakpoint halt, a STEP/RUN executes bp_pc once before re-arming: an internal skip flag suppresses the compare for the first executed cycle.
  - Cycle limit: when cycle_count+1 == cyc_limit on an executed cycle, that cycle executes; next state HALT, reason=2.
  - STOP: current cycle executes; next state HALT, reason=3.
- cycle_count increments on each cpu_en=1 cycle and saturates at all-ones.
- Trace: each cpu_en=1 cycle pushes {pc, instruction}. If full, overwrite oldest, advance read pointer, set trace_ovf. trace_rd when empty is ignored.
- Simultaneous push and pop: when full, count unchanged and both pointers advance; otherwise count unchanged.
- trace_data is valid the same cycle as trace_valid (registered array, combinational read).

Decomposition:
- Package cpu_ctrl_pkg: state encodings, cmd encodings, halt_reason encodings.
- Sub-module trace_ring_buffer (parameters WIDTH, DEPTH): push/pop, overwrite-on-full, count, sticky overflow, clear.

Test Plan:
- Reset then STEP with pc=0x0004 -> exactly one cpu_en pulse, state=HALT, cycle_count=1, trace holds {0x0004, instr}.
- RUN, cyc_limit=5, pc incrementing -> 5 cpu_en cycles, HALT, halt_reason=2, cycle_count=5.
- RUN, bp_en=1, bp_pc=0x000C, PC 0,4,8,C -> 3 executed cycles, HALT, reason=1, no trace entry for 0x000C; then STEP -> 0x000C executes once, HALT.
- 10 executed cycles, TRACE_DEPTH=8 -> trace_count=8, trace_ovf=1, first pop returns the 3rd PC.
- STOP during RUN while trace_rd is asserted on a full buffer -> the STOP cycle executes and HALT follows with reason=3; count stays 8.
- Assert rst_n low mid-RUN -> cpu_en falls immediately, all outputs at reset values. CLEAR after a HALT -> IDLE, count/reason/trace cleared.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run controller: run states, host commands, halt reasons.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2,
      ST_HALT = 2'd3
   } run_state_t;

   typedef enum logic [1:0] {
      CMD_RUN   = 2'd0,
      CMD_STEP  = 2'd1,
      CMD_STOP  = 2'd2,
      CMD_CLEAR = 2'd3
   } cmd_t;

   typedef enum logic [1:0] {
      HR_NONE  = 2'd0,
      HR_BP    = 2'd1,
      HR_LIMIT = 2'd2,
      HR_STOP  = 2'd3
   } halt_t;

endpackage

// File: rtl/trace_ring_buffer.sv
// Circular PC/instruction trace store. A push into a full buffer overwrites the
// oldest entry and sets a sticky overflow flag; reads are combinational from the head.
module trace_ring_buffer #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic             full;
   logic             pop_ok;
   logic             adv_rd;

   assign full   = (cnt_q == CNT_W'(DEPTH));
   assign pop_ok = pop && (cnt_q != '0);
   // A push into a full buffer drops the oldest entry, so the head moves too.
   assign adv_rd = pop_ok || (push && full);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (adv_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop_ok && !full) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else if (pop_ok && !push) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (push && full && !pop_ok) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign dout  = mem[rd_ptr];
   assign valid = (cnt_q != '0);
   assign count = cnt_q;
   assign ovf   = ovf_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/step/stop/breakpoint controller gating the CPU core clock enable, with a
// saturating executed-cycle counter and a trace of every executed cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset or CLEAR; core frozen, waiting for RUN/STEP
// RUN     | core free-running until breakpoint, cycle limit or STOP
// STEP    | core executes exactly one cycle, then HALT
// HALT    | core frozen; halt_reason tells why; RUN/STEP resume
module cpu_run_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int PC_W        = 16,
   parameter int INSTR_W     = 20,
   parameter int CYC_W       = 16,
   parameter int TRACE_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   input  logic [1:0]                    cmd,
   output logic                          cmd_ready,
   input  logic                          bp_en,
   input  logic [PC_W-1:0]               bp_pc,
   input  logic [CYC_W-1:0]              cyc_limit,
   input  logic [PC_W-1:0]               pc,
   input  logic [INSTR_W-1:0]            instruction,
   output logic                          cpu_en,
   output logic [1:0]                    state,
   output logic [CYC_W-1:0]              cycle_count,
   output logic [1:0]                    halt_reason,
   input  logic                          trace_rd,
   output logic                          trace_valid,
   output logic [PC_W+INSTR_W-1:0]       trace_data,
   output logic [$clog2(TRACE_DEPTH):0]  trace_count,
   output logic                          trace_ovf
);

   run_state_t       state_q, state_d;
   halt_t            reason_q, reason_d;
   logic             skip_q, skip_d;
   logic [CYC_W-1:0] count_q;
   cmd_t             cmd_c;
   logic             active;
   logic             bp_hit;
   logic             exec;
   logic             limit_hit;
   logic             cmd_fire;
   logic             stop_req;
   logic             clear_req;

   assign cmd_c  = cmd_t'(cmd);
   assign active = (state_q == ST_RUN) || (state_q == ST_STEP);
   // skip_q lets the instruction we halted on execute once before re-arming.
   assign bp_hit = active && bp_en && !skip_q && (pc == bp_pc);
   assign exec   = active && !bp_hit;

   assign cmd_ready = (state_q != ST_RUN) || (cmd_c == CMD_STOP);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign stop_req  = cmd_fire && (cmd_c == CMD_STOP);
   assign clear_req = cmd_fire && (cmd_c == CMD_CLEAR) && !active;

   assign limit_hit = exec && (cyc_limit != '0) && ((count_q + CYC_W'(1)) == cyc_limit);

   always_comb begin
      state_d  = state_q;
      reason_d = reason_q;
      skip_d   = exec ? 1'b0 : skip_q;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (cmd_fire) begin
               case (cmd_c)
                  CMD_RUN:   state_d = ST_RUN;
                  CMD_STEP:  state_d = ST_STEP;
                  CMD_CLEAR: begin
                     state_d  = ST_IDLE;
                     reason_d = HR_NONE;
                     skip_d   = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN, ST_STEP: begin
            if (bp_hit) begin
               state_d  = ST_HALT;
               reason_d = HR_BP;
               skip_d   = 1'b1;
            end else if (limit_hit) begin
               state_d  = ST_HALT;
               reason_d = HR_LIMIT;
            end else if (stop_req) begin
               state_d  = ST_HALT;
               reason_d = HR_STOP;
            end else if (state_q == ST_STEP) begin
               state_d  = ST_HALT;
               reason_d = HR_NONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         reason_q <= HR_NONE;
         skip_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         reason_q <= reason_d;
         skip_q   <= skip_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear_req) begin
         count_q <= '0;
      end else if (exec && (count_q != '1)) begin
         count_q <= count_q + CYC_W'(1);
      end
   end

   trace_ring_buffer #(
      .WIDTH (PC_W + INSTR_W),
      .DEPTH (TRACE_DEPTH)
   ) u_trace (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (exec),
      .pop   (trace_rd),
      .clear (clear_req),
      .din   ({pc, instruction}),
      .dout  (trace_data),
      .valid (trace_valid),
      .count (trace_count),
      .ovf   (trace_ovf)
   );

   assign cpu_en      = exec;
   assign state       = state_q;
   assign halt_reason = reason_q;
   assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed and randomized bench for cpu_run_controller against a queue-based
// behavioural model of the run/halt rules and the trace buffer.
module tb_cpu_run_controller;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 20;
   localparam int CYC_W   = 16;
   localparam int DEPTH   = 8;
   localparam int TW      = PC_W + INSTR_W;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 cmd_valid;
   logic [1:0]           cmd;
   logic                 cmd_ready;
   logic                 bp_en;
   logic [PC_W-1:0]      bp_pc;
   logic [CYC_W-1:0]     cyc_limit;
   logic [PC_W-1:0]      pc;
   logic [INSTR_W-1:0]   instruction;
   logic                 cpu_en;
   logic [1:0]           state;
   logic [CYC_W-1:0]     cycle_count;
   logic [1:0]           halt_reason;
   logic                 trace_rd;
   logic                 trace_valid;
   logic [TW-1:0]        trace_data;
   logic [$clog2(DEPTH):0] trace_count;
   logic                 trace_ovf;

   cpu_run_controller #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .CYC_W(CYC_W), .TRACE_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
      .bp_en(bp_en), .bp_pc(bp_pc), .cyc_limit(cyc_limit), .pc(pc), .instruction(instruction),
      .cpu_en(cpu_en), .state(state), .cycle_count(cycle_count), .halt_reason(halt_reason),
      .trace_rd(trace_rd), .trace_valid(trace_valid), .trace_data(trace_data),
      .trace_count(trace_count), .trace_ovf(trace_ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: spec-level state number, reason, skip-once flag, count, trace queue.
   int          m_state;
   int          m_reason;
   bit          m_skip;
   int unsigned m_count;
   bit          m_ovf;
   logic [TW-1:0] q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state  = 0;
      m_reason = 0;
      m_skip   = 1'b0;
      m_count  = 0;
      m_ovf    = 1'b0;
      q.delete();
   endtask

   // Called just after a falling edge with inputs settled: checks outputs, then
   // advances the model across the next rising edge.
   task automatic cyc();
      bit running, bp, en, rdy, fire, limit;
      running = (m_state == 1) || (m_state == 2);
      bp      = running && bp_en && !m_skip && (pc == bp_pc);
      en      = running && !bp;
      rdy     = (m_state != 1) || (cmd == 2'd2);
      fire    = cmd_valid && rdy;
      limit   = en && (cyc_limit != 0) && ((m_count + 1) == 32'(cyc_limit));
      #1;
      chk("cpu_en", 64'(cpu_en), 64'(en));
      chk("cmd_ready", 64'(cmd_ready), 64'(rdy));
      chk("state", 64'(state), 64'(m_state));
      chk("cycle_count", 64'(cycle_count), 64'(m_count));
      chk("halt_reason", 64'(halt_reason), 64'(m_reason));
      chk("trace_count", 64'(trace_count), 64'(q.size()));
      chk("trace_valid", 64'(trace_valid), 64'(q.size() > 0));
      chk("trace_ovf", 64'(trace_ovf), 64'(m_ovf));
      if (q.size() > 0) chk("trace_data", 64'(trace_data), 64'(q[0]));

      if (trace_rd && q.size() > 0) void'(q.pop_front());
      if (en) begin
         if (m_count < 32'hFFFF) m_count++;
         q.push_back({pc, instruction});
         if (q.size() > DEPTH) begin
            void'(q.pop_front());
            m_ovf = 1'b1;
         end
         m_skip = 1'b0;
      end
      if (running) begin
         if (bp) begin
            m_state = 3; m_reason = 1; m_skip = 1'b1;
         end else if (limit) begin
            m_state = 3; m_reason = 2;
         end else if (fire && cmd == 2'd2) begin
            m_state = 3; m_reason = 3;
         end else if (m_state == 2) begin
            m_state = 3; m_reason = 0;
         end
      end else if (fire) begin
         case (cmd)
            2'd0: m_state = 1;
            2'd1: m_state = 2;
            2'd3: begin
               m_state = 0; m_reason = 0; m_count = 0; m_skip = 1'b0; m_ovf = 1'b0;
               q.delete();
            end
            default: ;
         endcase
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [1:0] c);
      cmd_valid = 1'b1;
      cmd = c;
      cyc();
      cmd_valid = 1'b0;
   endtask

   logic [INSTR_W-1:0] step_instr;
   logic [PC_W-1:0]    pcs[5];
   logic [CYC_W-1:0]   lims[4];

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd = 2'd0; bp_en = 1'b0; bp_pc = '0;
      cyc_limit = '0; pc = '0; instruction = '0; trace_rd = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_cpu_en", 64'(cpu_en), 64'd0);
      chk("rst_state", 64'(state), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      cyc();

      // single step at 0x0004
      send(2'd1);
      pc = 16'h0004;
      step_instr = INSTR_W'($urandom);
      instruction = step_instr;
      cyc();
      cyc();
      chk("step_state", 64'(state), 64'd3);
      chk("step_count", 64'(cycle_count), 64'd1);
      chk("step_trace", 64'(trace_data), 64'({16'h0004, step_instr}));
      send(2'd3);
      cyc();

      // cycle limit of 5
      cyc_limit = 16'd5;
      pc = '0;
      send(2'd0);
      for (int i = 0; i < 7; i++) begin
         pc = PC_W'(i * 4);
         instruction = INSTR_W'($urandom);
         cyc();
      end
      chk("limit_reason", 64'(halt_reason), 64'd2);
      chk("limit_count", 64'(cycle_count), 64'd5);
      cyc_limit = '0;
      send(2'd3);

      // breakpoint at 0x000C, then step over it
      bp_en = 1'b1;
      bp_pc = 16'h000C;
      pc = '0;
      send(2'd0);
      for (int i = 0; i < 6; i++) begin
         pc = (i < 3) ? PC_W'(i * 4) : 16'h000C;
         instruction = INSTR_W'($urandom);
         cyc();
      end
      chk("bp_reason", 64'(halt_reason), 64'd1);
      chk("bp_count", 64'(cycle_count), 64'd3);
      chk("bp_trace_count", 64'(trace_count), 64'd3);
      send(2'd1);
      cyc();
      cyc();
      chk("bp_step_state", 64'(state), 64'd3);
      chk("bp_step_reason", 64'(halt_reason), 64'd0);
      chk("bp_step_count", 64'(cycle_count), 64'd4);
      bp_en = 1'b0;
      send(2'd3);

      // overflow after 10 executed cycles, then STOP with a concurrent pop
      pc = '0;
      send(2'd0);
      for (int i = 0; i < 10; i++) begin
         pc = PC_W'(i * 4);
         instruction = INSTR_W'($urandom);
         cyc();
      end
      chk("ovf_count", 64'(trace_count), 64'd8);
      chk("ovf_flag", 64'(trace_ovf), 64'd1);
      chk("ovf_head_pc", 64'(trace_data[TW-1:INSTR_W]), 64'h8);
      pc = 16'd40;
      trace_rd = 1'b1;
      send(2'd2);
      trace_rd = 1'b0;
      cyc();
      chk("stop_reason", 64'(halt_reason), 64'd3);
      chk("stop_trace_count", 64'(trace_count), 64'd8);
      chk("stop_cycles", 64'(cycle_count), 64'd11);
      trace_rd = 1'b1;
      cyc();
      trace_rd = 1'b0;
      cyc();

      // asynchronous reset in the middle of a run
      send(2'd0);
      for (int i = 0; i < 3; i++) begin
         pc = PC_W'($urandom);
         cyc();
      end
      chk("pre_rst_en", 64'(cpu_en), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_en", 64'(cpu_en), 64'd0);
      chk("mid_rst_state", 64'(state), 64'd0);
      chk("mid_rst_count", 64'(cycle_count), 64'd0);
      chk("mid_rst_trace", 64'(trace_count), 64'd0);
      chk("mid_rst_ovf", 64'(trace_ovf), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      // randomized traffic
      pcs[0] = 16'h0000; pcs[1] = 16'h0004; pcs[2] = 16'h0008; pcs[3] = 16'h000C; pcs[4] = 16'h0010;
      lims[0] = 16'd0; lims[1] = 16'd3; lims[2] = 16'd9; lims[3] = 16'd40;
      for (int n = 0; n < 800; n++) begin
         cmd_valid   = ($urandom_range(0, 3) == 0);
         cmd         = 2'($urandom_range(0, 3));
         pc          = pcs[$urandom_range(0, 4)];
         instruction = INSTR_W'($urandom);
         trace_rd    = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) bp_en = ~bp_en;
         if ($urandom_range(0, 31) == 0) cyc_limit = lims[$urandom_range(0, 3)];
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
